uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: OVERSAMPLE, 16, Rxclk_en ticks per bit period; legal values are even and 8..16.
REQ-002 Parameter: DATA_BITS, 8, data bits per frame, sent LSB first.
REQ-003 Port: clk_50m  input  1  system clock, 50 MHz; single clock domain.
REQ-004 Port: clr  input  1  reset, synchronous, active-high.
REQ-005 Port: Rx  input  1  serial line, asynchronous to clk_50m, idles high.
REQ-006 Port: Rxclk_en  input  1  one-clk_50m-cycle enable pulse from the baud generator, at OVERSAMPLE x baud (115200 x 16).
REQ-007 Port: rdy_clr  input  1  consumer acknowledge; clears rdy and overrun.
REQ-008 Port: data_out  output  DATA_BITS  last good received byte.
REQ-009 Port: rdy  output  1  a new byte is valid on data_out.
REQ-010 Port: frame_err  output  1  the last frame had a low stop bit.
REQ-011 Port: overrun  output  1  a byte was overwritten while rdy was still 1.
REQ-012 Port (UART_RX_PARITY_EN only): parity_err  output  1  the last frame had an even-parity mismatch.

Function
REQ-013 Rx shall pass through a 2-flop synchronizer before use; all decisions shall use the synchronized value (rx_s).
REQ-014 The FSM shall have states IDLE, START, DATA, STOP, plus PARITY when the macro is defined.
REQ-015 The FSM and the sample counter shall advance only on cycles where Rxclk_en=1.
REQ-016 Sample counter: log2(OVERSAMPLE) bits, wraps at OVERSAMPLE-1.
REQ-017 IDLE: on a tick with rx_s=0, go to START with the counter at 0; otherwise stay in IDLE.
REQ-018 START: at counter=OVERSAMPLE/2-1 (mid start bit):
- rx_s=0: reset the counter, go to DATA.
- rx_s=1: false start, go to IDLE; no output changes.
REQ-019 DATA: at counter=OVERSAMPLE-1, shift rx_s into bit[index] of an internal buffer; after the DATA_BITS-th bit go to STOP (or PARITY).
REQ-020 STOP: at counter=OVERSAMPLE-1, return to IDLE in all cases.
- rx_s=1: data_out<=buffer, rdy<=1, frame_err<=0.
- rx_s=0: frame_err<=1; data_out and rdy unchanged.
REQ-021 Latency: rdy and data_out shall update on the clk_50m edge that follows the Rxclk_en cycle in which the stop bit is sampled.
REQ-022 rdy_clr=1 shall clear rdy and overrun on the next edge.
REQ-023 If rdy_clr and a byte completion occur in the same cycle, the completion wins: rdy=1 and overrun stays 0.
REQ-024 If a byte completes while rdy=1 and rdy_clr=0: data_out is overwritten and overrun<=1; overrun stays set until rdy_clr.
REQ-025 frame_err (and parity_err) shall hold until the next completed frame.
REQ-026 Back-to-back frames: a start edge seen on the first tick after STOP shall be accepted with no idle gap required.

Reset
REQ-027 While clr=1 on a clk_50m edge:
- State, counter, index and buffer shall reset to IDLE/0.
- Outputs shall reset to data_out=0, rdy=0, frame_err=0, overrun=0, parity_err=0.
- Synchronizer flops shall reset to 1.
REQ-028 clr asserted mid-frame shall abandon the frame; after release, reception shall resume at the next falling edge of rx_s.

Configuration
REQ-029 Macro UART_RX_PARITY_EN.
- Defined: one even-parity bit follows the data bits. PARITY samples it at counter=OVERSAMPLE-1. A good stop bit sets parity_err to the mismatch result; data_out and rdy update even on mismatch.
- Undefined: the frame is 8N1, the PARITY state and the parity_err port do not exist.

Structure
REQ-030 Package uart_pkg holds:
- the FSM state enum;
- OVERSAMPLE_DEF=16, DATA_BITS_DEF=8 and BAUD=115200 constants.
REQ-031 One sub-module, rx_sync: 2-flop synchronizer with reset value 1.

Verification
REQ-032 Frame 0xA5, 8N1, at 16 ticks/bit -> data_out=0xA5, rdy=1 one clk after the mid-stop tick, frame_err=0.
REQ-033 Rx low for 4 ticks then high -> no rdy; FSM is back in IDLE; a following 0x3C frame is received correctly.
REQ-034 Frame 0x55 with stop bit=0 -> frame_err=1, rdy stays 0, data_out keeps its previous value.
REQ-035 Two frames 0x11 then 0x22 without rdy_clr -> data_out=0x22, overrun=1; then rdy_clr -> rdy=0, overrun=0.
REQ-036 clr pulsed during data bit 4 of 0xFF -> all outputs 0; the next frame 0x81 is received correctly.
REQ-037 With UART_RX_PARITY_EN, frame 0x07 with parity bit=0 -> parity_err=1, data_out=0x07, rdy=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receiver.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam int BAUD           = 115200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/uart_receiver_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so an idle line never looks like a start bit.
`timescale 1ns/1ps
module rx_sync (
  input  logic clk_50m,
  input  logic clr,
  input  logic rx_i,
  output logic rx_s_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_50m) begin
    if (clr) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_s_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver (8N1 by default, DATA_BITS LSB first).
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
`timescale 1ns/1ps
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk_50m,
  input  logic                 clr,
  input  logic                 Rx,
  input  logic                 Rxclk_en,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 stop_done;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  rx_sync u_rx_sync (
    .clk_50m (clk_50m),
    .clr     (clr),
    .rx_i    (Rx),
    .rx_s_o  (rx_s)
  );

  always_ff @(posedge clk_50m) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Everything in the frame path moves only on oversample ticks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    if (Rxclk_en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (!rx_s) state_d = ST_START;
        end
        ST_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d   = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            buf_d[idx_q] = rx_s;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            par_d   = rx_s;
            state_d = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A completing frame overrides a simultaneous acknowledge.
  always_comb begin
    stop_done = Rxclk_en && (state_q == ST_STOP) && (cnt_q == CNT_LAST);
    data_d    = data_q;
    rdy_d     = rdy_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
`ifdef UART_RX_PARITY_EN
    perr_d    = perr_q;
`endif
    if (rdy_clr) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (stop_done) begin
      if (rx_s) begin
        data_d = buf_q;
        rdy_d  = 1'b1;
        ferr_d = 1'b0;
        if (rdy_q && !rdy_clr) ovr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        perr_d = ^{buf_q, par_q};
`endif
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign data_out  = data_q;
  assign rdy       = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
